frame_ram_read_arbiter: RTL and testbench
=========================================

Name: frame_ram_read_arbiter

Overview:
- Shares the single read port (port B) of the 784-byte MNIST frame RAM between two requesters.
- Requester 0 is the VGA image blitter; requester 1 is the inference engine's pixel fetcher.
- Per-requester req/gnt ownership with bounded bursts and round-robin fairness; returns tagged read data after the RAM latency.
- Can freeze new grants while the Arduino capture is writing a frame, so readers never see a torn image.

Parameters:
- ADDR_W, 10, RAM address width.
- DATA_W, 8, pixel width.
- NUM_PIX, 784, valid address range 0..NUM_PIX-1.
- RAM_LAT, 1, cycles from ram_addr_b presentation to valid ram_dout_b (1..4).
- BURST_MAX, 32, max reads per ownership when the other requester waits; 0 = unlimited.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high reset
- hold  in  1  capture writing; no new grants while high
- req0  in  1  requester 0 wants/keeps ownership; a read is issued each cycle it is high while owned
- addr0  in  ADDR_W  requester 0 read address
- gnt0  out  1  requester 0 owns port
- rvalid0  out  1  rdata0 valid (single-cycle pulse per read)
- rdata0  out  DATA_W  read data for requester 0
- req1/addr1/gnt1/rvalid1/rdata1  same as above, for requester 1
- ram_addr_b  out  ADDR_W  to frame RAM port B
- ram_dout_b  in  DATA_W  from frame RAM port B
- busy  out  1  high when any owner or in-flight read exists

Behaviour:
- Reset (async, immediate) values:
  - State IDLE; gnt0=gnt1=0; rvalid0=rvalid1=0; busy=0; ram_addr_b=0.
  - Round-robin pointer set so requester 0 wins the first tie; burst counter 0; read pipeline flushed (in-flight reads dropped, never returned).
- States: IDLE, OWN0, OWN1. gnt_i is a registered decode of state (gnt_i=1 exactly when state==OWN_i).
- Read issue:
  - In OWN_i with req_i=1, ram_addr_b=addr_i combinationally (mux on state) and one read is issued.
  - In IDLE, ram_addr_b=0.
  - In OWN_i with req_i=0, no read is issued and ram_addr_b holds addr_i.
- Return:
  - A read issued in cycle t raises rvalid_i in cycle t+RAM_LAT.
  - rdata_i = ram_dout_b in that cycle, or 0 if the issued address was >= NUM_PIX (out-of-range flag carried in the pipeline). rdata_i is a don't-care when rvalid_i=0.
- Transitions from IDLE (only when hold=0):
  - Only req0 → OWN0; only req1 → OWN1.
  - Both → the requester not served last.
  - With hold=1, stay in IDLE.
- Transitions from OWN_i:
  - req_i=0: go to OWN_j if req_j=1 and hold=0, else IDLE. No idle bubble between owners.
  - req_i=1, BURST_MAX≠0, this is read number BURST_MAX of the ownership, req_j=1, hold=0: go to OWN_j next cycle (forced rotation). Otherwise stay.
- Burst counter:
  - Resets to 0 on every entry to OWN_x.
  - Increments per issued read and saturates at BURST_MAX.
  - Never forces rotation when the other requester is idle.
- hold:
  - Does not revoke current ownership; the owner may finish.
  - Blocks both IDLE exits and rotations to the other requester.
- Last-served pointer updates on every entry to OWN_x.
- busy = (state≠IDLE) or any valid bit in the read pipeline.
- Requester contract: a requester must ignore rvalid/rdata not preceded by its own issued read. The arbiter guarantees returns arrive in issue order, each tagged to the correct requester, including across an owner switch where reads to both are in flight.

Decomposition:
- Package mnist_fb_pkg holds:
  - NUM_PIX=784, FB_ADDR_W=10, FB_DATA_W=8.
  - Requester ID constants REQ_BLIT=0, REQ_NN=1.
  - arb_state enum {IDLE, OWN0, OWN1}.
- One natural sub-module, fb_read_tag_pipe: a RAM_LAT-deep shift register of {valid, id, oob} that produces rvalid0/rvalid1 and the zero-force select.

Test Plan:
- Reset, then req0=1 only with addr0=0,1,2,3: gnt0=1 one cycle after req0. With RAM_LAT=1, rvalid0 pulses 4 times, one cycle after each issue, carrying RAM[0..3]. rvalid1 never asserts.
- req0 and req1 both raised in the same cycle from IDLE after reset: OWN0 first. Drop req0 → OWN1 the next cycle, with no IDLE cycle between.
- BURST_MAX=32, both held high: exactly 32 reads to 0, then 32 to 1, alternating. With only req0 high for 100 cycles, 100 consecutive reads and no rotation.
- hold=1 while IDLE with req1=1: gnt1 stays 0 until hold falls, then asserts one cycle later. hold=1 during OWN0 with req1 pending: no rotation at burst limit; OWN0 continues.
- addr0=800 (≥784) issued: rvalid0 pulses with rdata0=0. A preceding addr0=783 returns RAM[783] correctly.
- reset asserted with 1 read in flight (RAM_LAT=2): gnt/rvalid drop immediately, and no rvalid appears after reset release.

Source files
------------

// File: rtl/mnist_fb_pkg.sv
// rtl/mnist_fb_pkg.sv - shared constants and types for the MNIST frame-buffer read path
package mnist_fb_pkg;

   localparam int NUM_PIX   = 784;
   localparam int FB_ADDR_W = 10;
   localparam int FB_DATA_W = 8;

   // Requester identities as carried in the read tag
   localparam logic REQ_BLIT = 1'b0;
   localparam logic REQ_NN   = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state;

   // One in-flight read: who asked, and whether the address was past the frame
   typedef struct packed {
      logic valid;
      logic id;
      logic oob;
   } rd_tag_t;

endpackage

// File: rtl/fb_read_tag_pipe.sv
// rtl/fb_read_tag_pipe.sv - RAM-latency-matched tag pipeline steering read returns
module fb_read_tag_pipe
   import mnist_fb_pkg::*;
#(
   parameter int RAM_LAT = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic i_valid,
   input  logic i_id,
   input  logic i_oob,
   output logic o_rvalid0,
   output logic o_rvalid1,
   output logic o_zero,
   output logic o_any_valid
);

   rd_tag_t r_pipe [RAM_LAT];
   rd_tag_t w_in;
   rd_tag_t w_out;

   assign w_in  = '{valid: i_valid, id: i_id, oob: i_oob};
   assign w_out = r_pipe[RAM_LAT-1];

   // Shift tags alongside the RAM; reset drops every in-flight read
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < RAM_LAT; i++) begin
            r_pipe[i] <= '0;
         end
      end else begin
         r_pipe[0] <= w_in;
         for (int i = 1; i < RAM_LAT; i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
      end
   end

   assign o_rvalid0 = w_out.valid && (w_out.id == REQ_BLIT);
   assign o_rvalid1 = w_out.valid && (w_out.id == REQ_NN);
   assign o_zero    = w_out.oob;

   // Any stage holding a read keeps the arbiter busy
   always_comb begin
      o_any_valid = 1'b0;
      for (int i = 0; i < RAM_LAT; i++) begin
         o_any_valid = o_any_valid | r_pipe[i].valid;
      end
   end

endmodule

// File: rtl/frame_ram_read_arbiter.sv
// rtl/frame_ram_read_arbiter.sv - two-requester burst/round-robin arbiter for frame RAM port B
module frame_ram_read_arbiter
   import mnist_fb_pkg::*;
#(
   parameter int ADDR_W    = FB_ADDR_W,
   parameter int DATA_W    = FB_DATA_W,
   parameter int NUM_PIX   = 784,
   parameter int RAM_LAT   = 1,
   parameter int BURST_MAX = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              hold,
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   output logic              gnt0,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] ram_addr_b,
   input  logic [DATA_W-1:0] ram_dout_b,
   output logic              busy
);

   // Burst counter just wide enough to hold BURST_MAX (it saturates there)
   localparam int BW           = (BURST_MAX < 1) ? 1 : $clog2(BURST_MAX + 1);
   localparam int BURST_LAST_I = (BURST_MAX < 1) ? 0 : BURST_MAX - 1;
   localparam logic [BW-1:0]     BURST_LAST = BW'(BURST_LAST_I);
   localparam logic [BW-1:0]     BURST_SAT  = BW'(BURST_MAX);
   localparam logic [ADDR_W:0]   OOB_LIM    = (ADDR_W + 1)'(NUM_PIX);

   arb_state          r_state;
   arb_state          w_next;
   logic              r_gnt0;
   logic              r_gnt1;
   logic              r_last;
   logic [BW-1:0]     r_burst;
   logic [ADDR_W-1:0] w_addr;
   logic              w_issue;
   logic              w_issue_id;
   logic              w_oob;
   logic              w_burst_done;
   logic              w_enter;
   logic              w_zero;
   logic              w_any_valid;

   // Port B address follows the current owner; idle parks at zero
   always_comb begin
      w_addr = '0;
      case (r_state)
         OWN0:    w_addr = addr0;
         OWN1:    w_addr = addr1;
         default: w_addr = '0;
      endcase
   end

   assign ram_addr_b   = w_addr;
   assign w_issue      = ((r_state == OWN0) && req0) || ((r_state == OWN1) && req1);
   assign w_issue_id   = (r_state == OWN1);
   assign w_oob        = ({1'b0, w_addr} >= OOB_LIM);
   // Counter holds reads already done; this read is number BURST_MAX (or later, once saturated)
   assign w_burst_done = (BURST_MAX != 0) && (r_burst >= BURST_LAST);
   assign w_enter      = (w_next != r_state) && (w_next != IDLE);

   // Ownership FSM: hold only blocks new grants, never revokes the current one
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (!hold) begin
               if (req0 && req1) begin
                  w_next = (r_last == REQ_BLIT) ? OWN1 : OWN0;
               end else if (req0) begin
                  w_next = OWN0;
               end else if (req1) begin
                  w_next = OWN1;
               end
            end
         end
         OWN0: begin
            if (!req0) begin
               w_next = (req1 && !hold) ? OWN1 : IDLE;
            end else if (w_burst_done && req1 && !hold) begin
               w_next = OWN1;
            end
         end
         OWN1: begin
            if (!req1) begin
               w_next = (req0 && !hold) ? OWN0 : IDLE;
            end else if (w_burst_done && req0 && !hold) begin
               w_next = OWN0;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // State register with grants decoded from the next state so they track it exactly
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_gnt0  <= 1'b0;
         r_gnt1  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_gnt0  <= (w_next == OWN0);
         r_gnt1  <= (w_next == OWN1);
      end
   end

   // Burst length restarts on each new ownership and saturates at the limit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_burst <= '0;
      end else if (w_enter) begin
         r_burst <= '0;
      end else if (w_issue && (r_burst != BURST_SAT)) begin
         r_burst <= r_burst + 1'b1;
      end
   end

   // Last-served pointer starts at the NN side so the blitter wins the first tie
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_last <= REQ_NN;
      end else if (w_enter) begin
         r_last <= (w_next == OWN1) ? REQ_NN : REQ_BLIT;
      end
   end

   fb_read_tag_pipe #(
      .RAM_LAT (RAM_LAT)
   ) u_tag_pipe (
      .clk         (clk),
      .reset       (reset),
      .i_valid     (w_issue),
      .i_id        (w_issue_id),
      .i_oob       (w_oob),
      .o_rvalid0   (rvalid0),
      .o_rvalid1   (rvalid1),
      .o_zero      (w_zero),
      .o_any_valid (w_any_valid)
   );

   assign gnt0   = r_gnt0;
   assign gnt1   = r_gnt1;
   assign rdata0 = w_zero ? '0 : ram_dout_b;
   assign rdata1 = w_zero ? '0 : ram_dout_b;
   assign busy   = (r_state != IDLE) || w_any_valid;

endmodule

// File: tb/tb_frame_ram_read_arbiter.sv
// tb/tb_frame_ram_read_arbiter.sv - self-checking bench for frame_ram_read_arbiter
module tb_frame_ram_read_arbiter;

   localparam int AW = 10;
   localparam int DW = 8;
   localparam int NP = 784;
   localparam int BM = 32;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   // DUT A: RAM_LAT=1, fully modelled
   logic          reset, hold, req0, req1;
   logic [AW-1:0] addr0, addr1, ram_addr_b;
   logic [DW-1:0] rdata0, rdata1, ram_dout_b;
   logic          gnt0, gnt1, rvalid0, rvalid1, busy;

   // DUT B: RAM_LAT=2, used for latency and reset-in-flight checks
   logic          b_reset, b_hold, b_req0, b_req1;
   logic [AW-1:0] b_addr0, b_addr1, b_ram_addr;
   logic [DW-1:0] b_rdata0, b_rdata1, b_dout, b_d1;
   logic          b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_busy;

   frame_ram_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUM_PIX(NP), .RAM_LAT(1), .BURST_MAX(BM)) u_dut (
      .clk(clk), .reset(reset), .hold(hold),
      .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
      .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
      .ram_addr_b(ram_addr_b), .ram_dout_b(ram_dout_b), .busy(busy)
   );

   frame_ram_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUM_PIX(NP), .RAM_LAT(2), .BURST_MAX(BM)) u_dut_b (
      .clk(clk), .reset(b_reset), .hold(b_hold),
      .req0(b_req0), .addr0(b_addr0), .gnt0(b_gnt0), .rvalid0(b_rvalid0), .rdata0(b_rdata0),
      .req1(b_req1), .addr1(b_addr1), .gnt1(b_gnt1), .rvalid1(b_rvalid1), .rdata1(b_rdata1),
      .ram_addr_b(b_ram_addr), .ram_dout_b(b_dout), .busy(b_busy)
   );

   // RAM contents are nonzero everywhere, so a zeroed out-of-range return is visible
   function automatic logic [7:0] ram_val(input logic [AW-1:0] a);
      logic [31:0] t;
      t = 32'(a) * 32'd7 + 32'h35;
      return t[7:0] | 8'h01;
   endfunction

   always @(posedge clk) ram_dout_b <= ram_val(ram_addr_b);
   always @(posedge clk) begin
      b_d1   <= ram_val(b_ram_addr);
      b_dout <= b_d1;
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model of DUT A plus return scoreboard
   typedef struct {
      int         due;
      bit         id;
      logic [7:0] data;
   } sb_t;
   sb_t sb[$];

   int m_state, m_ns, m_burst, m_burst_n, cyc_n;
   bit m_last, m_last_n;

   task automatic model_reset();
      m_state = 0;
      m_last  = 1'b1;
      m_burst = 0;
      sb.delete();
   endtask

   task automatic half1();
      logic [AW-1:0] ma;
      bit            iss;
      sb_t           e;
      @(negedge clk);
      ma  = (m_state == 1) ? addr0 : (m_state == 2) ? addr1 : '0;
      iss = ((m_state == 1) && req0) || ((m_state == 2) && req1);
      chk("gnt0", 32'(gnt0), 32'(m_state == 1));
      chk("gnt1", 32'(gnt1), 32'(m_state == 2));
      chk("ram_addr_b", 32'(ram_addr_b), 32'(ma));
      chk("busy", 32'(busy), 32'((m_state != 0) || (sb.size() != 0)));
      if (rvalid0 && rvalid1) begin
         chk("rvalid_both", 32'(rvalid1), 32'(0));
      end else if (rvalid0 || rvalid1) begin
         if (sb.size() == 0) begin
            chk("spurious_rvalid", 32'(rvalid0 | rvalid1), 32'(0));
         end else begin
            e = sb.pop_front();
            chk("ret_cycle", 32'(cyc_n), 32'(e.due));
            chk("ret_id", 32'(rvalid1), 32'(e.id));
            chk("ret_data", 32'(rvalid1 ? rdata1 : rdata0), 32'(e.data));
         end
      end else if ((sb.size() != 0) && (sb[0].due <= cyc_n)) begin
         chk("missing_rvalid", 32'(0), 32'(1));
         void'(sb.pop_front());
      end
      if (iss) begin
         e.due  = cyc_n + 1;
         e.id   = (m_state == 2);
         e.data = (32'(ma) < NP) ? ram_val(ma) : 8'h00;
         sb.push_back(e);
      end
      // Next-state model
      m_ns = m_state;
      if (m_state == 0) begin
         if (!hold) begin
            if (req0 && req1) m_ns = m_last ? 1 : 2;
            else if (req0)    m_ns = 1;
            else if (req1)    m_ns = 2;
         end
      end else begin
         bit mine, other;
         mine  = (m_state == 1) ? req0 : req1;
         other = (m_state == 1) ? req1 : req0;
         if (!mine)
            m_ns = (other && !hold) ? 3 - m_state : 0;
         else if (BM != 0 && (m_burst + 1) >= BM && other && !hold)
            m_ns = 3 - m_state;
      end
      m_burst_n = m_burst;
      m_last_n  = m_last;
      if (m_ns != m_state && m_ns != 0) begin
         m_burst_n = 0;
         m_last_n  = (m_ns == 2);
      end else if (iss && m_burst < BM) begin
         m_burst_n = m_burst + 1;
      end
   endtask

   task automatic half2();
      @(posedge clk);
      #1;
      m_state = m_ns;
      m_burst = m_burst_n;
      m_last  = m_last_n;
      cyc_n++;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         half1();
         half2();
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      chk("rst_gnt0", 32'(gnt0), 32'(0));
      chk("rst_gnt1", 32'(gnt1), 32'(0));
      chk("rst_rvalid", 32'(rvalid0 | rvalid1), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_addr", 32'(ram_addr_b), 32'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   typedef struct {
      bit            rst, r0, r1, hd;
      logic [AW-1:0] a0, a1;
      bit            eg0, eg1, erv0, erv1;
   } vec_t;
   vec_t tbl[$];

   function automatic vec_t mk(bit rst, bit r0, int a0, bit r1, int a1, bit hd,
                               bit eg0, bit eg1, bit erv0, bit erv1);
      vec_t v;
      v.rst = rst; v.r0 = r0; v.a0 = AW'(a0); v.r1 = r1; v.a1 = AW'(a1); v.hd = hd;
      v.eg0 = eg0; v.eg1 = eg1; v.erv0 = erv0; v.erv1 = erv1;
      return v;
   endfunction

   int runs_len[$];
   int runs_own[$];
   int prev_own, cur_own, run_len, cnt;

   initial begin
      reset = 1'b1; hold = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
      b_reset = 1'b1; b_hold = 1'b0; b_req0 = 1'b0; b_req1 = 1'b0; b_addr0 = '0; b_addr1 = '0;
      cyc_n = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0; b_reset = 1'b0;

      // rst r0 a0 r1 a1 hold | gnt0 gnt1 rv0 rv1
      tbl.push_back(mk(1, 0,  0, 0,  0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1,  0, 0,  0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1,  0, 0,  0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1,  1, 0,  0, 0, 1, 0, 1, 0));
      tbl.push_back(mk(0, 1,  2, 0,  0, 0, 1, 0, 1, 0));
      tbl.push_back(mk(0, 1,  3, 0,  0, 0, 1, 0, 1, 0));
      tbl.push_back(mk(0, 0,  3, 0,  0, 0, 1, 0, 1, 0));
      tbl.push_back(mk(0, 0,  0, 0,  0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0,  0, 0,  0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 10, 1, 20, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 10, 1, 20, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 10, 1, 20, 0, 1, 0, 1, 0));
      tbl.push_back(mk(0, 0, 10, 1, 20, 0, 1, 0, 1, 0));
      tbl.push_back(mk(0, 0, 10, 1, 20, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 10, 0, 20, 0, 0, 1, 0, 1));
      tbl.push_back(mk(0, 0,  0, 0,  0, 0, 0, 0, 0, 0));

      foreach (tbl[i]) begin
         req0 = tbl[i].r0; addr0 = tbl[i].a0; req1 = tbl[i].r1; addr1 = tbl[i].a1; hold = tbl[i].hd;
         if (tbl[i].rst) begin
            do_reset();
         end else begin
            half1();
            chk($sformatf("vec%0d_gnt0", i), 32'(gnt0), 32'(tbl[i].eg0));
            chk($sformatf("vec%0d_gnt1", i), 32'(gnt1), 32'(tbl[i].eg1));
            chk($sformatf("vec%0d_rv0", i), 32'(rvalid0), 32'(tbl[i].erv0));
            chk($sformatf("vec%0d_rv1", i), 32'(rvalid1), 32'(tbl[i].erv1));
            half2();
         end
      end

      // Both requesters saturating: bursts of exactly BM, alternating, blitter first
      req0 = 1'b1; req1 = 1'b1; addr0 = 10'd100; addr1 = 10'd200;
      prev_own = -1; run_len = 0;
      for (int i = 0; i < 140; i++) begin
         half1();
         cur_own = gnt0 ? 0 : (gnt1 ? 1 : -1);
         if (cur_own == prev_own) begin
            run_len++;
         end else begin
            if (prev_own != -1) begin
               runs_len.push_back(run_len);
               runs_own.push_back(prev_own);
            end
            run_len = 1;
            prev_own = cur_own;
         end
         half2();
      end
      chk("burst_runs_seen", 32'(runs_len.size() >= 3), 32'(1));
      chk("burst_first_owner", 32'(runs_own[0]), 32'(0));
      foreach (runs_len[k]) begin
         chk($sformatf("burst_len%0d", k), 32'(runs_len[k]), 32'(BM));
         if (k > 0) chk($sformatf("burst_alt%0d", k), 32'(runs_own[k] != runs_own[k-1]), 32'(1));
      end
      req0 = 1'b0; req1 = 1'b0;
      tick(3);

      // Lone requester is never rotated away
      cnt = 0;
      req0 = 1'b1;
      for (int i = 0; i < 101; i++) begin
         addr0 = AW'(i * 5);
         half1();
         if (gnt0) cnt++;
         half2();
      end
      chk("solo_reads", 32'(cnt), 32'(100));
      req0 = 1'b0;
      tick(3);

      // hold keeps IDLE from granting; grant follows one cycle after release
      hold = 1'b1; req1 = 1'b1; addr1 = 10'd42;
      for (int i = 0; i < 6; i++) begin
         half1();
         chk("hold_idle_gnt1", 32'(gnt1), 32'(0));
         half2();
      end
      hold = 1'b0;
      half1(); chk("hold_rel_gnt1_a", 32'(gnt1), 32'(0)); half2();
      half1(); chk("hold_rel_gnt1_b", 32'(gnt1), 32'(1)); half2();
      req1 = 1'b0;
      tick(3);

      // hold during OWN0 blocks the forced rotation at the burst limit
      req0 = 1'b1; addr0 = 10'd5;
      tick(2);
      req1 = 1'b1; hold = 1'b1;
      for (int i = 0; i < 40; i++) begin
         half1();
         chk("hold_own0", 32'(gnt0), 32'(1));
         half2();
      end
      hold = 1'b0;
      tick(1);
      half1(); chk("hold_rel_rotate", 32'(gnt1), 32'(1)); half2();
      req0 = 1'b0; req1 = 1'b0;
      tick(4);

      // Last valid pixel returns data; out-of-range address returns zero
      req0 = 1'b1; addr0 = 10'd783;
      tick(2);
      addr0 = 10'd800;
      half1();
      chk("oob_prev_rv", 32'(rvalid0), 32'(1));
      chk("oob_prev_data", 32'(rdata0), 32'(ram_val(10'd783)));
      half2();
      req0 = 1'b0;
      half1();
      chk("oob_rv", 32'(rvalid0), 32'(1));
      chk("oob_data", 32'(rdata0), 32'(0));
      half2();
      tick(4);
      chk("sb_drained", 32'(sb.size()), 32'(0));

      // DUT B: two-cycle return latency
      b_req0 = 1'b1; b_addr0 = 10'd7;
      @(posedge clk); #1;
      @(posedge clk); #1;
      b_req0 = 1'b0;
      @(negedge clk); chk("lat2_early", 32'(b_rvalid0), 32'(0));
      @(posedge clk); #1;
      @(negedge clk);
      chk("lat2_rv", 32'(b_rvalid0), 32'(1));
      chk("lat2_data", 32'(b_rdata0), 32'(ram_val(10'd7)));
      @(posedge clk); #1;

      // DUT B: reset with a read in flight drops it
      b_req0 = 1'b1; b_addr0 = 10'd9;
      @(posedge clk); #1;
      @(posedge clk); #1;
      b_req0 = 1'b0;
      chk("inflight_busy", 32'(b_busy), 32'(1));
      chk("inflight_gnt0", 32'(b_gnt0), 32'(1));
      b_reset = 1'b1;
      #1;
      chk("arst_gnt0", 32'(b_gnt0), 32'(0));
      chk("arst_rvalid", 32'(b_rvalid0 | b_rvalid1), 32'(0));
      chk("arst_busy", 32'(b_busy), 32'(0));
      @(posedge clk); @(posedge clk); #1;
      b_reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("post_rst_rvalid", 32'(b_rvalid0 | b_rvalid1), 32'(0));
         chk("post_rst_gnt", 32'(b_gnt0 | b_gnt1), 32'(0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
